// File: rtl/dac_frame_player_if.sv
// AXI-Stream bundle shared by the loader (slave) and DAC (master) sides of
// dac_frame_player.
//   tvalid / tready : beat handshake
//   tdata           : DATA_WIDTH-bit payload
//   tstrb           : one strobe bit per byte
//   tlast           : end-of-frame marker
interface dac_frame_player_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/dac_frame_player.sv
// dac_frame_player: loads a waveform of 16-bit samples from a 32-bit stream,
// packs eight samples per 128-bit word into a frame buffer, and replays the
// whole frame to the DAC stream on every laser trigger until a reload.
// Ports:
//   s00_axis_aclk      single clock for both streams
//   s00_axis_aresetn   asynchronous active-low reset
//   s00_axis           loader stream (slave), sample in tdata[15:0]
//   m00_axis           DAC stream (master), earliest sample in tdata[15:0]
//   laser_trigger      start playback when armed (level)
//   frame_reload       return to loading when armed (wins over trigger)
//   frame_armed        high while a frame is armed and idle
//   frame_len          words in the stored frame minus one
module dac_frame_player #(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 128,
    parameter int unsigned FRAME_WORDS            = 128
) (
    input  logic               s00_axis_aclk,
    input  logic               s00_axis_aresetn,
    dac_frame_player_if.slave  s00_axis,
    dac_frame_player_if.master m00_axis,
    input  logic               laser_trigger,
    input  logic               frame_reload,
    output logic               frame_armed,
    output logic [7:0]         frame_len
);
    localparam int unsigned LANES  = C_M00_AXIS_TDATA_WIDTH / 16;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned ADDR_W = $clog2(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {StLoading, StArmed, StPlaying} state_e;

    state_e r_state;
    state_e w_state_next;

    logic [LANE_W-1:0]                 r_lane;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_pack;
    logic [ADDR_W-1:0]                 r_word_addr;
    logic [ADDR_W-1:0]                 r_frame_len;
    logic [ADDR_W-1:0]                 r_rd_addr;
    logic                              r_rd_done;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_rdata;
    logic                              r_rvalid;
    logic                              r_rlast;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_buf [FRAME_WORDS];

    logic                              w_s_ready;
    logic                              w_armed;
    logic                              w_s_hs;
    logic                              w_m_hs;
    logic                              w_lane_full;
    logic                              w_word_done;
    logic                              w_frame_done;
    logic                              w_rd_en;
    logic                              w_trigger;
    logic                              w_reload;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] w_packed;
    logic                              w_unused_bits;

    // Upper loader bits and strobes carry nothing.
    assign w_unused_bits = ^{s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1:16], s00_axis.tstrb};

    assign w_s_hs       = w_s_ready & s00_axis.tvalid;
    assign w_m_hs       = r_rvalid & m00_axis.tready;
    assign w_lane_full  = (r_lane == LAST_LANE);
    assign w_word_done  = w_s_hs & (w_lane_full | s00_axis.tlast);
    assign w_frame_done = w_s_hs & (s00_axis.tlast | (w_lane_full & (r_word_addr == LAST_ADDR)));
    assign w_reload     = (r_state == StArmed) & frame_reload;
    assign w_trigger    = (r_state == StArmed) & ~frame_reload & laser_trigger;

    // The read register is the output register: a new word is fetched only
    // when the current one is absent or leaves this cycle, so data holds
    // during stalls and a held-high tready gives one beat per cycle.
    assign w_rd_en = (r_state == StPlaying) & ~r_rd_done & (~r_rvalid | m00_axis.tready);

    // Current word with the incoming sample merged into its lane.
    always_comb begin
        w_packed = r_pack;
        w_packed[r_lane*16 +: 16] = s00_axis.tdata[15:0];
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_state <= StLoading;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_armed      = 1'b0;
        unique case (r_state)
            StLoading: begin
                w_s_ready = 1'b1;
                if (w_frame_done) w_state_next = StArmed;
            end
            StArmed: begin
                w_armed = 1'b1;
                if (frame_reload) begin
                    w_state_next = StLoading;
                end else if (laser_trigger) begin
                    w_state_next = StPlaying;
                end
            end
            StPlaying: begin
                if (w_m_hs && r_rlast) w_state_next = StArmed;
            end
            default: w_state_next = StLoading;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_lane      <= '0;
            r_pack      <= '0;
            r_word_addr <= '0;
            r_frame_len <= '0;
            r_rd_addr   <= '0;
            r_rd_done   <= 1'b0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
        end else begin
            if (w_s_hs) begin
                if (w_word_done) begin
                    r_lane <= '0;
                    r_pack <= '0;
                    // Address stays on the final word so it never wraps.
                    if (!w_frame_done) r_word_addr <= r_word_addr + ADDR_W'(1);
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                    r_pack <= w_packed;
                end
            end
            if (w_frame_done) r_frame_len <= r_word_addr;

            if (w_reload) begin
                r_word_addr <= '0;
                r_lane      <= '0;
                r_pack      <= '0;
            end

            if (w_trigger) begin
                r_rd_addr <= '0;
                r_rd_done <= 1'b0;
            end

            if (w_rd_en) begin
                r_rdata  <= r_buf[r_rd_addr];
                r_rlast  <= (r_rd_addr == r_frame_len);
                r_rvalid <= 1'b1;
                if (r_rd_addr == r_frame_len) begin
                    r_rd_done <= 1'b1;
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                end
            end else if (w_m_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Frame buffer has no reset: contents survive reset and reload.
    always_ff @(posedge s00_axis_aclk) begin
        if (w_word_done) r_buf[r_word_addr] <= w_packed;
    end

    assign s00_axis.tready = w_s_ready;
    assign m00_axis.tvalid = r_rvalid;
    assign m00_axis.tdata  = r_rdata;
    assign m00_axis.tlast  = r_rlast & r_rvalid;
    assign m00_axis.tstrb  = '1;
    assign frame_armed     = w_armed;
    assign frame_len       = 8'(r_frame_len);
endmodule
